// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with combinational hit path
// and a word-at-a-time line refill from backing memory over a valid handshake.
module icache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        icache_stall,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_valid
);

    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TW = 30 - OB - IB;

    typedef enum logic {IDLE, FILL} state_t;

    state_t          state_reg, state_next;
    logic [OB-1:0]   cnt_reg, cnt_next;
    logic [31:0]     base_reg, base_next;
    logic [LINES-1:0] valid_reg;
    logic [TW-1:0]   tag_mem  [LINES];
    logic [31:0]     data_mem [LINES][WORDS];

    logic [OB-1:0]   a_off;
    logic [IB-1:0]   a_idx;
    logic [TW-1:0]   a_tag;
    logic [IB-1:0]   b_idx;
    logic [TW-1:0]   b_tag;
    logic            hit;
    logic            in_fill;
    logic            fill_last;

    assign a_off     = addr[2+OB-1:2];
    assign a_idx     = addr[2+OB+IB-1:2+OB];
    assign a_tag     = addr[31:2+OB+IB];
    assign b_idx     = base_reg[2+OB+IB-1:2+OB];
    assign b_tag     = base_reg[31:2+OB+IB];
    assign hit       = valid_reg[a_idx] && (tag_mem[a_idx] == a_tag);
    assign in_fill   = (state_reg == FILL);
    assign fill_last = in_fill && mem_valid && (cnt_reg == OB'(WORDS - 1));

    // Memory request is a pure decode of registered state so it is stable from the edge.
    assign mem_rd       = in_fill;
    assign mem_addr     = in_fill ? {base_reg[31:2+OB], cnt_reg, 2'b00} : 32'd0;
    assign icache_stall = in_fill || (req && !hit);
    assign instr        = (req && hit) ? data_mem[a_idx][a_off] : 32'd0;

    // State, refill counter and captured line base.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            base_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            base_reg  <= base_next;
        end
    end

    // Next-state: start a fill on a lookup miss, step through the line, abort on flush.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        base_next  = base_reg;
        case (state_reg)
            IDLE: begin
                if (req && !hit && !flush) begin
                    base_next  = {addr[31:2+OB], {(2+OB){1'b0}}};
                    cnt_next   = '0;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (flush) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (mem_valid) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (fill_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-line valid bit: the line being refilled stays invalid until its last word lands.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (in_fill && (b_idx == IB'(gi))) begin
                    valid_reg[gi] <= fill_last;
                end
            end
        end
    endgenerate

    // Data and tag storage; no reset needed since valid bits gate every hit.
    always_ff @(posedge clk) begin
        if (in_fill && mem_valid && !flush) begin
            data_mem[b_idx][cnt_reg] <= mem_data;
        end
        if (fill_last && !flush) begin
            tag_mem[b_idx] <= b_tag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed checks of hit/miss timing, refill addressing, wait states,
// flush abort and asynchronous reset for the icache.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] instr;
    logic        icache_stall;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_valid;

    int checks = 0;
    int errors = 0;
    int waits  = 0;
    int wait_cnt = 0;

    icache #(.LINES(16), .WORDS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .addr         (addr),
        .flush        (flush),
        .instr        (instr),
        .icache_stall (icache_stall),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_valid    (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: each word holds its own address; answers after 'waits' idle cycles.
    assign mem_data  = mem_addr;
    assign mem_valid = mem_rd && (wait_cnt >= waits);

    always @(posedge clk) begin
        if (mem_rd && !mem_valid) wait_cnt <= wait_cnt + 1;
        else                      wait_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Called in cycle 0 of a miss (inputs already applied). Runs until stall drops,
    // checking the refill address sequence, then checks stall length and the served word.
    task automatic run_fill(input logic [31:0] a, input int w, input string tag);
        int stalls;
        int k;
        logic [31:0] base;
        base   = {a[31:4], 4'h0};
        stalls = 0;
        k      = 0;
        while (icache_stall === 1'b1 && stalls < 200) begin
            if (stalls == 0) begin
                chk({tag, " c0 mem_rd"}, {31'd0, mem_rd}, 32'd0);
            end else begin
                chk({tag, " fill mem_rd"}, {31'd0, mem_rd}, 32'd1);
                chk({tag, " fill mem_addr"}, mem_addr, base + 32'(4 * (k / (w + 1))));
                k++;
            end
            stalls++;
            @(negedge clk);
            #1;
        end
        chk({tag, " stall cycles"}, 32'(stalls), 32'(1 + 4 * (w + 1)));
        chk({tag, " instr"}, instr, {a[31:2], 2'b00});
        chk({tag, " mem_rd after"}, {31'd0, mem_rd}, 32'd0);
    endtask

    initial begin
        rst   = 1'b0;
        req   = 1'b1;
        addr  = 32'h100;
        flush = 1'b0;
        waits = 0;
        #1;
        // Reset state
        chk("rst stall", {31'd0, icache_stall}, 32'd1);
        chk("rst instr", instr, 32'd0);
        chk("rst mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Cold miss at 0x100
        run_fill(32'h100, 0, "cold");

        // Hit sweep
        for (int i = 1; i < 4; i++) begin
            addr = 32'h100 + 32'(4 * i);
            #1;
            chk("hit instr", instr, 32'h100 + 32'(4 * i));
            chk("hit stall", {31'd0, icache_stall}, 32'd0);
            chk("hit mem_rd", {31'd0, mem_rd}, 32'd0);
            @(negedge clk);
            #1;
        end

        // req=0 on a missing address: no stall, no fill started
        req  = 1'b0;
        addr = 32'h200;
        #1;
        chk("noreq stall", {31'd0, icache_stall}, 32'd0);
        chk("noreq instr", instr, 32'd0);
        @(negedge clk);
        #1;
        chk("noreq mem_rd", {31'd0, mem_rd}, 32'd0);

        // Conflict miss: 0x200 shares index 0 with 0x100
        req = 1'b1;
        #1;
        run_fill(32'h200, 0, "conflict");
        addr = 32'h100;
        #1;
        chk("evicted stall", {31'd0, icache_stall}, 32'd1);
        run_fill(32'h100, 0, "refill100");

        // Wait states: two idle cycles per word
        waits = 2;
        addr  = 32'h308;
        #1;
        run_fill(32'h308, 2, "wait");
        waits = 0;

        // Load a line at another index to observe the flush
        addr = 32'h514;
        #1;
        run_fill(32'h514, 0, "line1");

        // Flush during the 2nd FILL word of 0x400
        addr = 32'h400;
        #1;
        chk("fl c0 stall", {31'd0, icache_stall}, 32'd1);
        @(negedge clk); #1;
        chk("fl w0 addr", mem_addr, 32'h400);
        @(negedge clk); #1;
        chk("fl w1 addr", mem_addr, 32'h404);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req   = 1'b0;
        #1;
        chk("fl abort mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("fl abort stall", {31'd0, icache_stall}, 32'd0);
        req  = 1'b1;
        addr = 32'h514;
        #1;
        chk("fl line1 miss", {31'd0, icache_stall}, 32'd1);
        addr = 32'h400;
        #1;
        chk("fl 400 miss", {31'd0, icache_stall}, 32'd1);
        run_fill(32'h400, 0, "after flush");

        // Reset during the 3rd word of a fill
        addr = 32'h100;
        #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rmid w2 addr", mem_addr, 32'h108);
        #1;
        rst = 1'b0;
        #1;
        chk("rmid mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rmid mem_addr", mem_addr, 32'd0);
        chk("rmid stall", {31'd0, icache_stall}, 32'd1);
        chk("rmid instr", instr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        run_fill(32'h100, 0, "post reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
